// File: rtl/i2c_tof_arbiter.sv
// Round-robin arbiter sharing one I2C master engine between N_REQ ToF sensor drivers.
// Optional build macro I2C_ARB_PRIO0_EN gives requester 0 fixed top priority.
module i2c_tof_arbiter #(
   parameter int N_REQ       = 4,
   parameter int TIMEOUT_CYC = 65535,
   parameter int TO_W        = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [7*N_REQ-1:0]    req_addr,
   input  logic [16*N_REQ-1:0]   req_reg,
   input  logic [N_REQ-1:0]      req_is_read,
   input  logic [10*N_REQ-1:0]   req_nbytes,
   input  logic [8*N_REQ-1:0]    req_wdata,
   output logic [N_REQ-1:0]      req_ack,
   output logic [N_REQ-1:0]      rsp_valid,
   output logic [15:0]           rsp_data,
   output logic                  rsp_error,
   output logic                  busy,
   output logic [2:0]            grant_id,
   output logic [6:0]            i2c_slave_adress,
   output logic [15:0]           i2c_register_address,
   output logic                  i2c_is_read,
   output logic [9:0]            i2c_nb_of_bytes,
   output logic [7:0]            i2c_data_in,
   output logic                  i2c_start,
   output logic                  i2c_reset,
   input  logic                  i2c_ready,
   input  logic [15:0]           i2c_data_out,
   input  logic                  i2c_error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_BUSY,
      S_DONE,
      S_RECOVER
   } state_t;

   state_t          state, state_nx;
   logic [2:0]      ptr;
   logic [2:0]      win;
   logic [TO_W-1:0] to_cnt;
   logic            to_hit;
   logic            rec_cnt;

   assign to_hit = (to_cnt >= TO_W'(TIMEOUT_CYC));

   // Highest offset is visited first so the closest requester after ptr is the last writer.
   always_comb begin
      win = ptr;
      for (int k = N_REQ; k >= 1; k--) begin
         if (req_valid[(int'(ptr) + k) % N_REQ]) win = 3'((int'(ptr) + k) % N_REQ);
      end
`ifdef I2C_ARB_PRIO0_EN
      if (req_valid[0]) win = 3'd0;
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      // NOTE: every output gets a default before the case so no latch is inferred.
      state_nx  = state;
      i2c_start = 1'b0;
      i2c_reset = reset;
      rsp_valid = '0;
      busy      = (state != S_IDLE);
      unique case (state)
         S_IDLE:    if (|req_valid) state_nx = S_ISSUE;
         S_ISSUE: begin
            i2c_start = 1'b1;
            if (!i2c_ready)  state_nx = S_BUSY;
            else if (to_hit) state_nx = S_RECOVER;
         end
         S_BUSY: begin
            if (i2c_ready)   state_nx = S_DONE;
            else if (to_hit) state_nx = S_RECOVER;
         end
         S_RECOVER: begin
            i2c_reset = 1'b1;
            if (rec_cnt) state_nx = S_DONE;
         end
         S_DONE: begin
            rsp_valid = N_REQ'(1) << grant_id;
            state_nx  = S_IDLE;
         end
         default:   state_nx = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; every register here is reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         ptr                  <= 3'(N_REQ - 1);
         req_ack              <= '0;
         grant_id             <= '0;
         rsp_data             <= '0;
         rsp_error            <= 1'b0;
         to_cnt               <= '0;
         rec_cnt              <= 1'b0;
         i2c_slave_adress     <= '0;
         i2c_register_address <= '0;
         i2c_is_read          <= 1'b0;
         i2c_nb_of_bytes      <= '0;
         i2c_data_in          <= '0;
      end else begin
         req_ack <= '0;
         unique case (state)
            S_IDLE: begin
               if (|req_valid) begin
                  req_ack              <= N_REQ'(1) << win;
                  grant_id             <= win;
                  to_cnt               <= '0;
                  rec_cnt              <= 1'b0;
                  i2c_slave_adress     <= req_addr[7*int'(win) +: 7];
                  i2c_register_address <= req_reg[16*int'(win) +: 16];
                  i2c_is_read          <= req_is_read[win];
                  i2c_nb_of_bytes      <= req_nbytes[10*int'(win) +: 10];
                  i2c_data_in          <= req_wdata[8*int'(win) +: 8];
`ifdef I2C_ARB_PRIO0_EN
                  if (win != 3'd0) ptr <= win;
`else
                  ptr <= win;
`endif
               end
            end
            S_ISSUE, S_BUSY: begin
               if (!to_hit) to_cnt <= to_cnt + 1'b1;
               if (state == S_BUSY && i2c_ready) begin
                  rsp_data  <= i2c_data_out;
                  rsp_error <= i2c_error;
               end
            end
            S_RECOVER: begin
               rec_cnt   <= 1'b1;
               rsp_data  <= '0;
               rsp_error <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
